// File: rtl/seven_seg_capture.sv
// Receive side of the hex seven-segment display encoding: decodes two digit
// glyphs presented one per SegValid strobe and reassembles the original byte.
module seven_seg_capture #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       seg_valid,
  input  logic       dig_sel,
  output logic [7:0] value,
  output logic       value_valid,
  output logic [1:0] dp_out,
  output logic       pattern_err,
  output logic       seq_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    GOT_HI
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    hi;
  logic          dp_hi;
  logic          legal;
  logic [3:0]    nib;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (seg_in[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= 4'h0;
      dp_hi       <= 1'b0;
      value       <= 8'h00;
      dp_out      <= 2'b00;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (seg_valid) begin
            if (!legal) begin
              pattern_err <= 1'b1;
            end else if (!dig_sel) begin
              hi    <= nib;
              dp_hi <= seg_in[7];
              cnt   <= '0;
              state <= GOT_HI;
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        GOT_HI: begin
          if (seg_valid) begin
            cnt <= '0;
            if (!legal) begin
              pattern_err <= 1'b1;
              state       <= IDLE;
            end else if (dig_sel) begin
              value       <= {hi, nib};
              dp_out      <= {dp_hi, seg_in[7]};
              value_valid <= 1'b1;
              state       <= IDLE;
            end else begin
              seq_err <= 1'b1;
              hi      <= nib;
              dp_hi   <= seg_in[7];
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // This idle edge is the one on which the count would reach TIMEOUT.
            seq_err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == GOT_HI);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: directed scenarios push expected
// pulses (kind, value, dp, cycle) and a monitor pops and compares them.
module tb_seven_seg_capture;

  localparam int TO = 4;
  localparam logic [2:0] K_VAL = 3'b100;
  localparam logic [2:0] K_PAT = 3'b010;
  localparam logic [2:0] K_SEQ = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_in;
  logic       seg_valid;
  logic       dig_sel;
  logic [7:0] value;
  logic       value_valid;
  logic [1:0] dp_out;
  logic       pattern_err;
  logic       seq_err;
  logic       busy;

  seven_seg_capture #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .dig_sel    (dig_sel),
    .value      (value),
    .value_valid(value_valid),
    .dp_out     (dp_out),
    .pattern_err(pattern_err),
    .seq_err    (seq_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] val;
    logic [1:0] dp;
    int         at;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change on the falling edge and are sampled on the next rising edge.
  task automatic drive(input logic v, input logic sel, input logic [7:0] seg);
    @(negedge clk);
    seg_valid = v;
    dig_sel   = sel;
    seg_in    = seg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Called right after the drive whose sampling edge produces the pulse.
  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] val, input logic [1:0] dp);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.dp   = dp;
    e.at   = cyc + 1;
    q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      logic [2:0] kind;
      ev_t e;
      after_edge();
      kind = {value_valid, pattern_err, seq_err};
      if (kind != 3'b000) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'(kind), 32'd0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", 32'(kind), 32'(e.kind));
          check("pulse_cycle", 32'(cyc), 32'(e.at));
          if (e.kind == K_VAL) begin
            check("value", 32'(value), 32'(e.val));
            check("dp_out", 32'(dp_out), 32'(e.dp));
          end
        end
      end else if (q.size() > 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        check("missing_pulse", 32'd0, 32'(e.kind));
      end
    end
  end

  initial begin
    logic [1:0] dp;
    int         gap;
    rst       = 1'b1;
    seg_valid = 1'b0;
    dig_sel   = 1'b0;
    seg_in    = 8'h00;
    after_edge();
    after_edge();
    check("rst_value", 32'(value), 32'h00);
    check("rst_dp", 32'(dp_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({value_valid, pattern_err, seq_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pair: d then 2, Busy high for exactly one cycle.
    drive(1'b1, 1'b0, 8'b01011110);
    after_edge();
    check("pair_busy_hi", 32'(busy), 32'd1);
    drive(1'b1, 1'b1, 8'b01011011);
    expect_ev(K_VAL, 8'hD2, 2'b00);
    after_edge();
    check("pair_busy_lo", 32'(busy), 32'd0);
    idle(2);

    // Blank pattern from IDLE.
    drive(1'b1, 1'b0, 8'h00);
    expect_ev(K_PAT, 8'h00, 2'b00);
    after_edge();
    check("blank_busy", 32'(busy), 32'd0);
    check("blank_keeps_value", 32'(value), 32'hD2);
    idle(1);

    // Illegal dp-only digit 2 while holding digit 1.
    drive(1'b1, 1'b0, 8'h3F);
    after_edge();
    check("dp_only_busy_hi", 32'(busy), 32'd1);
    drive(1'b1, 1'b1, 8'h80);
    expect_ev(K_PAT, 8'h00, 2'b00);
    after_edge();
    check("dp_only_busy_lo", 32'(busy), 32'd0);
    idle(2);

    // Ordering errors.
    drive(1'b1, 1'b1, 8'h06);
    expect_ev(K_SEQ, 8'h00, 2'b00);
    idle(1);
    drive(1'b1, 1'b0, 8'h06);
    drive(1'b1, 1'b0, 8'h71);
    expect_ev(K_SEQ, 8'h00, 2'b00);
    drive(1'b1, 1'b1, 8'h3F);
    expect_ev(K_VAL, 8'hF0, 2'b00);
    idle(2);

    // Timeout after TO idle cycles, then a stray digit 2.
    drive(1'b1, 1'b0, {1'b0, glyph[5]});
    idle(TO);
    expect_ev(K_SEQ, 8'h00, 2'b00);
    after_edge();
    check("timeout_busy", 32'(busy), 32'd0);
    idle(1);
    drive(1'b1, 1'b1, {1'b0, glyph[3]});
    expect_ev(K_SEQ, 8'h00, 2'b00);
    idle(2);

    // TO-1 idle cycles is still in time.
    drive(1'b1, 1'b0, {1'b1, glyph[4'hA]});
    idle(TO - 1);
    drive(1'b1, 1'b1, {1'b0, glyph[4'hB]});
    expect_ev(K_VAL, 8'hAB, 2'b10);
    idle(2);

    // Sweep every byte with random dp bits and random in-time gaps.
    for (int b = 0; b < 256; b++) begin
      logic [7:0] bv;
      bv  = 8'(b);
      dp  = 2'($urandom_range(0, 3));
      gap = $urandom_range(0, TO - 1);
      drive(1'b1, 1'b0, {dp[1], glyph[bv[7:4]]});
      idle(gap);
      drive(1'b1, 1'b1, {dp[0], glyph[bv[3:0]]});
      expect_ev(K_VAL, bv, dp);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // Reset in the middle of a pair.
    drive(1'b1, 1'b0, {1'b0, glyph[1]});
    after_edge();
    check("midrst_busy_hi", 32'(busy), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    seg_valid = 1'b0;
    after_edge();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_value", 32'(value), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, {1'b0, glyph[2]});
    expect_ev(K_SEQ, 8'h00, 2'b00);
    idle(4);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
